// File: rtl/node_pkg.sv
// node_pkg: shared types and header-field helpers for the node's link buffers.
//   flit_tag_t   - head/tail tags stored alongside each flit data word
//   link_state_e - four-phase link receiver states
//   trk_state_e  - packet tracker states
//   len_w / dest_*_lsb / hdr_width - header field offsets derived from
//                  MAX_PACKET_LEN and NET_ADDR
package node_pkg;

    typedef struct packed {
        logic head;
        logic tail;
    } flit_tag_t;

    localparam int unsigned TAG_W = 2;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_WAIT = 1'b1
    } link_state_e;

    typedef enum logic {
        TRK_HEAD = 1'b0,
        TRK_BODY = 1'b1
    } trk_state_e;

    // Width of the payload-length field in the header.
    function automatic int unsigned len_w(input int unsigned max_pkt_len);
        return $clog2(max_pkt_len);
    endfunction

    function automatic int unsigned dest_x_lsb(input int unsigned max_pkt_len);
        return len_w(max_pkt_len);
    endfunction

    function automatic int unsigned dest_y_lsb(input int unsigned max_pkt_len,
                                               input int unsigned net_addr);
        return len_w(max_pkt_len) + net_addr;
    endfunction

    // Total number of header bits that carry routing/length information.
    function automatic int unsigned hdr_width(input int unsigned max_pkt_len,
                                              input int unsigned net_addr);
        return len_w(max_pkt_len) + 2 * net_addr;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// link_fifo: synchronous first-word-fall-through FIFO for tagged flits.
//   clk_i, rst_ni - clock, synchronous active-low reset
//   push_i/wdata_i - write one entry (ignored when full)
//   pop_i/rdata_o  - rdata_o is the oldest entry; pop_i removes it (ignored when empty)
//   full_o/empty_o - occupancy flags from the count register
module link_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/link_rx_buffer.sv
// link_rx_buffer: receive side of one mesh link feeding a router input port.
// Completes the four-phase S_Req/S_Ack handshake, tags flits head/tail from
// the header length field, buffers them in link_fifo and offers them to the
// crossbar over Out_Valid/Out_Ready.
//   Clock, nReset         - clock, synchronous active-low reset
//   S_Req, S_Ack, S_Data  - upstream link (S_Data sampled in the capture cycle)
//   Out_Valid/Ready/Data  - FIFO head flit towards the router
//   Out_Head, Out_Tail    - tags of the presented flit
//   Flit_Count, Pkt_Count - statistics, present only with LINK_RX_STATS_EN
//                           defined; tied to zero otherwise
module link_rx_buffer
    import node_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_PACKET_LEN = 8,
    parameter int unsigned NET_ADDR       = 4,
    parameter int unsigned DEPTH          = 8
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  S_Req,
    output logic                  S_Ack,
    input  logic [DATA_WIDTH-1:0] S_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Data,
    output logic                  Out_Head,
    output logic                  Out_Tail,
    output logic [15:0]           Flit_Count,
    output logic [15:0]           Pkt_Count
);

    localparam int unsigned LEN_W   = len_w(MAX_PACKET_LEN);
    localparam int unsigned ENTRY_W = TAG_W + DATA_WIDTH;

    // Elaboration-time parameter sanity.
    if (hdr_width(MAX_PACKET_LEN, NET_ADDR) > DATA_WIDTH) begin : g_bad_hdr
        $error("header fields do not fit in DATA_WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end

    link_state_e       state_q, state_d;
    trk_state_e        trk_q, trk_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              ack_q, ack_d;
    logic              push;
    logic              pop;
    flit_tag_t         wr_tag;
    flit_tag_t         rd_tag;
    logic [ENTRY_W-1:0] rd_entry;
    logic              fifo_full;
    logic              fifo_empty;

    // Link handshake and packet tracking; tracker only moves on a FIFO write.
    always_comb begin
        state_d = state_q;
        trk_d   = trk_q;
        rem_d   = rem_q;
        ack_d   = ack_q;
        push    = 1'b0;
        wr_tag  = '0;

        case (state_q)
            RX_IDLE: begin
                if (S_Req && !fifo_full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (!S_Req) begin
                    ack_d   = 1'b0;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (push) begin
            if (trk_q == TRK_HEAD) begin
                wr_tag.head = 1'b1;
                if (S_Data[LEN_W-1:0] == '0) begin
                    wr_tag.tail = 1'b1;
                end else begin
                    rem_d = S_Data[LEN_W-1:0];
                    trk_d = TRK_BODY;
                end
            end else begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    wr_tag.tail = 1'b1;
                    trk_d       = TRK_HEAD;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= RX_IDLE;
            trk_q   <= TRK_HEAD;
            rem_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            trk_q   <= trk_d;
            rem_q   <= rem_d;
            ack_q   <= ack_d;
        end
    end

    link_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clock),
        .rst_ni  (nReset),
        .push_i  (push),
        .wdata_i ({wr_tag, S_Data}),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pop       = Out_Ready && !fifo_empty;
    assign rd_tag    = flit_tag_t'(rd_entry[ENTRY_W-1 -: TAG_W]);
    assign S_Ack     = ack_q;
    assign Out_Valid = !fifo_empty;
    // Stale storage is hidden while empty so the port reads zero.
    assign Out_Data  = fifo_empty ? '0 : rd_entry[DATA_WIDTH-1:0];
    assign Out_Head  = !fifo_empty && rd_tag.head;
    assign Out_Tail  = !fifo_empty && rd_tag.tail;

`ifdef LINK_RX_STATS_EN
    logic [15:0] flit_cnt_q;
    logic [15:0] pkt_cnt_q;

    // Free-running statistics, wrapping at 16 bits.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (push) begin
            flit_cnt_q <= flit_cnt_q + 16'd1;
            if (wr_tag.tail) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
        end
    end

    assign Flit_Count = flit_cnt_q;
    assign Pkt_Count  = pkt_cnt_q;
`else
    assign Flit_Count = '0;
    assign Pkt_Count  = '0;
`endif

endmodule

// File: tb/tb_link_rx_buffer.sv
// Bench for link_rx_buffer: directed scenarios followed by randomized packets,
// every cycle checked against a queue-based model of the link buffer.
module tb_link_rx_buffer;

    localparam int unsigned DW     = 32;
    localparam int unsigned MAXLEN = 8;
    localparam int unsigned DEPTH  = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic          s_req;
    logic          s_ack;
    logic [DW-1:0] s_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_head;
    logic          out_tail;
    logic [15:0]   flit_count;
    logic [15:0]   pkt_count;

    always #5 clk = ~clk;

    link_rx_buffer #(
        .DATA_WIDTH     (DW),
        .MAX_PACKET_LEN (MAXLEN),
        .NET_ADDR       (4),
        .DEPTH          (DEPTH)
    ) dut (
        .Clock      (clk),
        .nReset     (nreset),
        .S_Req      (s_req),
        .S_Ack      (s_ack),
        .S_Data     (s_data),
        .Out_Valid  (out_valid),
        .Out_Ready  (out_ready),
        .Out_Data   (out_data),
        .Out_Head   (out_head),
        .Out_Tail   (out_tail),
        .Flit_Count (flit_count),
        .Pkt_Count  (pkt_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        bit            h;
        bit            t;
    } ent_t;

    // Reference model state
    ent_t mq[$];
    bit   m_ack;
    int   m_left;
    int   m_flits;
    int   m_pkts;
    bit   fresh;
    bit   rand_ready;

    int compared;
    int mismatched;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        compared++;
        mismatched++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic check_outputs();
        logic [15:0] ef;
        logic [15:0] ep;
`ifdef LINK_RX_STATS_EN
        ef = 16'(m_flits);
        ep = 16'(m_pkts);
`else
        ef = 16'd0;
        ep = 16'd0;
`endif
        chk("s_ack", 32'(s_ack), 32'(m_ack));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].d);
            chk("out_head", 32'(out_head), 32'(mq[0].h));
            chk("out_tail", 32'(out_tail), 32'(mq[0].t));
        end else if (fresh) begin
            chk("out_data_rst", out_data, 32'd0);
            chk("out_head_rst", 32'(out_head), 32'd0);
            chk("out_tail_rst", 32'(out_tail), 32'd0);
        end
        chk("flit_count", 32'(flit_count), 32'(ef));
        chk("pkt_count", 32'(pkt_count), 32'(ep));
    endtask

    // One clock: model evaluates what the DUT samples at the edge, then compare.
    task automatic cycle();
        bit   full;
        bit   wr;
        bit   rd;
        ent_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (!nreset) begin
            mq.delete();
            m_ack   = 1'b0;
            m_left  = 0;
            m_flits = 0;
            m_pkts  = 0;
            fresh   = 1'b1;
        end else begin
            full  = (mq.size() == DEPTH);
            wr    = !m_ack && s_req && !full;
            rd    = (mq.size() > 0) && out_ready;
            m_ack = m_ack ? s_req : (s_req && !full);
            if (rd) void'(mq.pop_front());
            if (wr) begin
                e.d = s_data;
                if (m_left == 0) begin
                    e.h    = 1'b1;
                    m_left = int'(s_data % MAXLEN);
                    e.t    = (m_left == 0);
                end else begin
                    e.h    = 1'b0;
                    m_left = m_left - 1;
                    e.t    = (m_left == 0);
                end
                mq.push_back(e);
                m_flits++;
                if (e.t) m_pkts++;
                fresh = 1'b0;
            end
        end
        #1;
        check_outputs();
    endtask

    // Full four-phase transfer of one flit, bounded waits on each phase.
    task automatic send_flit(input logic [DW-1:0] d);
        bit ok;
        s_req  = 1'b1;
        s_data = d;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (s_ack) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("ack_rise");
        s_req  = 1'b0;
        s_data = $urandom;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (!s_ack) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("ack_fall");
    endtask

    task automatic send_packet(input int p);
        logic [DW-1:0] hdr;
        hdr      = $urandom;
        hdr[2:0] = 3'(p);
        send_flit(hdr);
        for (int i = 0; i < p; i++) send_flit($urandom);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rand_ready = 1'b0;
        nreset     = 1'b0;
        s_req      = 1'b0;
        s_data     = '0;
        out_ready  = 1'b0;
        fresh      = 1'b1;

        // Reset state
        repeat (3) cycle();
        nreset = 1'b1;
        cycle();

        // Single header, P=0, consumer ready
        out_ready = 1'b1;
        s_req     = 1'b1;
        s_data    = 32'h0000_0120;
        cycle();
        chk("t1_ack_rise", 32'(s_ack), 32'd1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_head", 32'(out_head), 32'd1);
        chk("t1_tail", 32'(out_tail), 32'd1);
        s_req = 1'b0;
        repeat (3) cycle();

        // Header P=3 plus three payloads, consumer stalled then drained
        out_ready = 1'b0;
        send_packet(3);
        out_ready = 1'b1;
        repeat (6) cycle();

        // Fill to DEPTH with the consumer stalled; ninth request must wait
        out_ready = 1'b0;
        send_packet(7);
        s_req  = 1'b1;
        s_data = 32'h0000_0a50;
        repeat (4) begin
            cycle();
            chk("ack_held_full", 32'(s_ack), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("no_write_on_pop_edge", 32'(s_ack), 32'd0);
        out_ready = 1'b0;
        cycle();
        chk("ack_after_pop", 32'(s_ack), 32'd1);
        chk("occupancy_full", 32'(mq.size()), 32'(DEPTH));
        s_req = 1'b0;
        repeat (2) cycle();
        out_ready = 1'b1;
        repeat (12) cycle();

        // Reset in the middle of a packet
        out_ready = 1'b0;
        send_flit(32'h0000_0013);
        send_flit($urandom);
        nreset = 1'b0;
        cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ack", 32'(s_ack), 32'd0);
        nreset = 1'b1;
        send_flit(32'h0000_0a58);
        chk("post_rst_head", 32'(out_head), 32'd1);
        chk("post_rst_tail", 32'(out_tail), 32'd1);
        out_ready = 1'b1;
        repeat (3) cycle();

        // Randomized packets with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) send_packet(int'($urandom_range(0, MAXLEN - 1)));
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (12) cycle();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
